mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max BUSY cycles without bus_ack_i before abort (range 1..255).
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous, active-low reset; sampled on rising edge of clk_i.
REQ-004 mem_read_i  in  1  load request from decode.
REQ-005 mem_write_i  in  1  store request from decode.
REQ-006 size_i  in  2  access size: 00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-007 unsigned_i  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-008 addr_i  in  32  byte address (datapath ALU result).
REQ-009 write_data_i  in  32  store data (datapath register rd2), right-aligned.
REQ-010 read_data_o  out  32  extended load data to datapath result mux.
REQ-011 stall_o  out  1  1 = hold datapath PC and register writes this cycle.
REQ-012 misalign_o  out  1  one-cycle pulse, misaligned access rejected.
REQ-013 timeout_o  out  1  one-cycle pulse, bus access aborted.
REQ-014 bus_req_o  out  1  bus request, registered.
REQ-015 bus_we_o  out  1  1 = write transaction.
REQ-016 bus_addr_o  out  32  word-aligned address, {addr_i[31:2],2'b00}.
REQ-017 bus_be_o  out  4  byte enables, bit k = byte lane k (little-endian).
REQ-018 bus_wdata_o  out  32  lane-replicated store data.
REQ-019 bus_ack_i  in  1  single-cycle completion strobe from memory.
REQ-020 bus_rdata_i  in  32  read data, valid when bus_ack_i = 1.

Function
REQ-021 FSM states IDLE, BUSY, DONE; encoding free.
REQ-022 IDLE, no request: stall_o = 0, bus_req_o = 0, state stays IDLE.
REQ-023 IDLE, request and aligned: stall_o = 1 combinationally the same cycle; bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o latched; bus_req_o = 1 from the next cycle; go BUSY.
REQ-024 mem_read_i and mem_write_i both 1: performed as a write only.
REQ-025 Alignment: halfword requires addr_i[0] = 0; word requires addr_i[1:0] = 0; byte is always aligned.
REQ-026 IDLE, misaligned request: no bus transaction, misalign_o = 1 and stall_o = 0 for that cycle, read_data_o = 0, stay IDLE.
REQ-027 Byte enables:
  - byte: 1 << addr[1:0]
  - halfword: 0011 when addr[1] = 0, else 1100
  - word: 1111
REQ-028 bus_wdata_o:
  - byte: data[7:0] replicated x4
  - halfword: data[15:0] replicated x2
  - word: data unchanged
REQ-029 BUSY: bus_req_o = 1 and stall_o = 1; addresses, enables and data held stable; cycle counter increments each cycle.
REQ-030 BUSY, bus_ack_i = 1: capture the extracted read lane, go DONE, bus_req_o = 0 next cycle.
REQ-031 BUSY, counter reaches TIMEOUT_CYCLES with no ack: timeout_o pulses; next cycle go DONE, bus_req_o = 0, captured data = 0.
REQ-032 DONE: stall_o = 0, read_data_o = captured value, always go IDLE; inputs ignored this cycle (no retrigger).
REQ-033 Load extraction: byte lane addr[1:0] or half lane addr[1], sign- or zero-extended per unsigned_i; word passed through unchanged.
REQ-034 read_data_o holds its last value until the next load completes; writes leave it unchanged.
REQ-035 bus_ack_i seen in IDLE or DONE: ignored.
REQ-036 Latency: ack in the first BUSY cycle gives 2 stall cycles; the access completes in the DONE cycle (3 cycles total).

Reset
REQ-037 rst_i = 0 at an edge: state IDLE, counter 0, bus_req_o = 0, bus_we_o = 0, bus_be_o = 0, bus_addr_o = 0, bus_wdata_o = 0, read_data_o = 0, misalign_o = 0, timeout_o = 0.
REQ-038 Reset in BUSY: bus_req_o = 0 the following cycle; a later ack is ignored; no read_data_o update.
REQ-039 stall_o = 0 while rst_i = 0.

Verification
REQ-040 Word load, addr 0x100, bus_rdata 0x8765_4321, ack in 1st BUSY cycle -> be 1111, stall 2 cycles, read_data_o 0x8765_4321 in DONE.
REQ-041 Signed byte load, addr 0x103, rdata 0x80FF_FFFF -> be 1000, read_data_o 0xFFFF_FF80; same with unsigned_i = 1 -> 0x0000_0080.
REQ-042 Halfword store, addr 0x102, data 0x1234_ABCD -> bus_we 1, be 1100, wdata 0xABCD_ABCD, bus_addr 0x100.
REQ-043 Word load, addr 0x101 -> misalign_o pulse, bus_req_o stays 0, stall_o 0.
REQ-044 TIMEOUT_CYCLES = 4, no ack -> bus_req high 4 cycles, timeout_o pulse, DONE with read_data_o 0, then IDLE.
REQ-045 rst_i low during BUSY, ack 2 cycles later -> bus_req_o 0 after the reset edge, read_data_o stays 0, state IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit bridging the datapath to a single-outstanding memory bus.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        timeout_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      state;
   logic [7:0]  cnt;
   logic [1:0]  sz, off;
   logic        uns, req, aligned, expire;
   logic [7:0]  lane8;
   logic [15:0] lane16;
   logic [31:0] load_val, wdata;
   logic [3:0]  be;
   always_comb begin
      req      = mem_read_i | mem_write_i;
      aligned  = size_i == 2'b00 ? 1'b1 : size_i == 2'b01 ? ~addr_i[0] : addr_i[1:0] == 2'b00;
      be       = size_i == 2'b00 ? 4'b0001 << addr_i[1:0] :
                 size_i == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata    = size_i == 2'b00 ? {4{write_data_i[7:0]}} :
                 size_i == 2'b01 ? {2{write_data_i[15:0]}} : write_data_i;
      expire   = state == BUSY && cnt == 8'(TIMEOUT_CYCLES - 1);
      lane8    = bus_rdata_i[{off, 3'b000} +: 8];
      lane16   = off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      load_val = sz == 2'b00 ? {{24{~uns & lane8[7]}}, lane8} :
                 sz == 2'b01 ? {{16{~uns & lane16[15]}}, lane16} : bus_rdata_i;
   end
   assign stall_o    = rst_i & ((state == BUSY) | ((state == IDLE) & req & aligned));
   assign misalign_o = rst_i & (state == IDLE) & req & ~aligned;
   // an ack arriving in the final allowed cycle wins over the timeout
   assign timeout_o  = rst_i & expire & ~bus_ack_i;
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         sz          <= '0;
         off         <= '0;
         uns         <= 1'b0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= '0;
         bus_wdata_o <= '0;
         read_data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req && aligned) begin
                  state       <= BUSY;
                  cnt         <= '0;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= mem_write_i;
                  bus_addr_o  <= {addr_i[31:2], 2'b00};
                  bus_be_o    <= be;
                  bus_wdata_o <= wdata;
                  sz          <= size_i;
                  off         <= addr_i[1:0];
                  uns         <= unsigned_i;
               end else if (req) begin
                  read_data_o <= '0;
               end
            end
            BUSY: begin
               if (bus_ack_i || expire) begin
                  state     <= DONE;
                  bus_req_o <= 1'b0;
                  if (!bus_we_o) read_data_o <= bus_ack_i ? load_val : '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
